lsu_resp: RTL and testbench

- Memory-side responder for the processor's LW/SW handshake.
- Owns the unified 512x32 instruction/data RAM, serves instruction fetch, and accepts host program loads while the core is idle.
- Executes one load or store per request with fixed multi-cycle latency.
- Returns load data with its destination register tag and a one-cycle done pulse, which the core's regfile write mux consumes.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_ram.sv | 53 +++++
 rtl/lsu_resp.sv | 187 ++++++++++++++++++
 tb/tb_lsu_resp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store responder and its clients.
package lsu_pkg;

    localparam int DEF_AW = 9;
    localparam int DEF_DW = 32;

    // Opcode fields of the memory instructions, shared with the core decoder.
    localparam logic [3:0] LW_ICODE = 4'h4;
    localparam logic [3:0] LW_IFUN  = 4'h0;
    localparam logic [3:0] SW_ICODE = 4'h4;
    localparam logic [3:0] SW_IFUN  = 4'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } lsu_op_e;

endpackage

// File: rtl/lsu_ram.sv
// Unified instruction/data RAM: one write port, two registered read ports
// (fetch and load), each read register with its own synchronous clear.
module lsu_ram
    import lsu_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          f_en,
    input  logic          f_clr,
    input  logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_rdata,
    input  logic          l_en,
    input  logic          l_clr,
    input  logic [AW-1:0] l_addr,
    output logic [DW-1:0] l_rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] l_rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output-register clears model the block RAM's synchronous output reset.
    always_ff @(posedge clk) begin
        if (f_clr) begin
            f_rdata_q <= '0;
        end else if (f_en) begin
            f_rdata_q <= mem[f_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (l_clr) begin
            l_rdata_q <= '0;
        end else if (l_en) begin
            l_rdata_q <= mem[l_addr];
        end
    end

    assign f_rdata = f_rdata_q;
    assign l_rdata = l_rdata_q;

endmodule

// File: rtl/lsu_resp.sv
// Memory-side responder for LW/SW with fixed latency, instruction fetch and host load.
// Optional LSU_STAT_EN adds saturating load/store counters (ld_cnt, st_cnt).
module lsu_resp
    import lsu_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          working,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] pc_addr,
    output logic [DW-1:0] instr,
    input  logic          LW,
    input  logic          SW,
    input  logic [DW-1:0] valE,
    input  logic [3:0]    dstE,
    input  logic [DW-1:0] st_data,
    output logic [DW-1:0] valM,
    output logic [3:0]    dstM,
    output logic          LW_DONE,
    output logic          busy,
    output logic          addr_err
`ifdef LSU_STAT_EN
    ,
    output logic [15:0]   ld_cnt,
    output logic [15:0]   st_cnt
`endif
);

    lsu_state_e    state_q, state_d;
    lsu_op_e       op_q, op_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [3:0]    dstm_q, dstm_d;

    logic accept;
    logic illegal;
    logic hi_nz;
    logic st_we;
    logic host_we;

    assign accept  = (state_q == IDLE) && (LW ^ SW);
    assign illegal = (state_q == IDLE) && LW && SW;
    assign hi_nz   = (valE >> AW) != '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(LAT - 1);
                    state_d = (LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (accept) begin
            op_d   = SW ? OP_ST : OP_LD;
            addr_d = valE[AW-1:0];
            tag_d  = dstE;
            data_d = st_data;
        end
        busy_d = (state_d != IDLE);
        err_d  = illegal || (accept && hi_nz);
        done_d = (state_q == RESP) && (op_q == OP_LD);
        dstm_d = done_d ? tag_q : dstm_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q   <= OP_LD;
            addr_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            dstm_q <= '0;
        end else begin
            op_q   <= op_d;
            addr_q <= addr_d;
            tag_q  <= tag_d;
            data_q <= data_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            done_q <= done_d;
            dstm_q <= dstm_d;
        end
    end

    // A store completes even if working has dropped, so it wins over the host port.
    assign st_we   = reset && (state_q == RESP) && (op_q == OP_ST);
    assign host_we = !working && host_wr;

    lsu_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clock),
        .we      (st_we || host_we),
        .waddr   (st_we ? addr_q : host_addr),
        .wdata   (st_we ? data_q : host_wdata),
        .f_en    (working && (state_q != RESP)),
        .f_clr   (!reset || !working),
        .f_addr  (pc_addr),
        .f_rdata (instr),
        .l_en    (done_d),
        .l_clr   (!reset),
        .l_addr  (addr_q),
        .l_rdata (valM)
    );

    assign dstM     = dstm_q;
    assign LW_DONE  = done_q;
    assign busy     = busy_q;
    assign addr_err = err_q;

`ifdef LSU_STAT_EN
    logic [15:0] ld_cnt_q, ld_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (state_q == RESP) begin
            if (op_q == OP_LD && ld_cnt_q != 16'hFFFF) begin
                ld_cnt_d = ld_cnt_q + 16'd1;
            end
            if (op_q == OP_ST && st_cnt_q != 16'hFFFF) begin
                st_cnt_d = st_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign ld_cnt = ld_cnt_q;
    assign st_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_resp.sv
// Directed self-checking bench for lsu_resp (LAT=2): host load, fetch,
// load/store round trips, illegal and wrapped requests, busy drop, reset abort.
module tb_lsu_resp;
    import lsu_pkg::*;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clock;
    logic          reset;
    logic          working;
    logic          host_wr;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [AW-1:0] pc_addr;
    logic [DW-1:0] instr;
    logic          LW;
    logic          SW;
    logic [DW-1:0] valE;
    logic [3:0]    dstE;
    logic [DW-1:0] st_data;
    logic [DW-1:0] valM;
    logic [3:0]    dstM;
    logic          LW_DONE;
    logic          busy;
    logic          addr_err;
`ifdef LSU_STAT_EN
    logic [15:0]   ld_cnt;
    logic [15:0]   st_cnt;
`endif

    int checks = 0;
    int errors = 0;

    lsu_resp #(
        .AW  (AW),
        .DW  (DW),
        .LAT (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .working    (working),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .pc_addr    (pc_addr),
        .instr      (instr),
        .LW         (LW),
        .SW         (SW),
        .valE       (valE),
        .dstE       (dstE),
        .st_data    (st_data),
        .valM       (valM),
        .dstM       (dstM),
        .LW_DONE    (LW_DONE),
        .busy       (busy),
        .addr_err   (addr_err)
`ifdef LSU_STAT_EN
        ,
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_wr    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_wr    = 1'b0;
        $display("host write addr=%0d data=%h", a, d);
    endtask

    task automatic do_store(input logic [DW-1:0] va, input logic [DW-1:0] d, input logic exp_err);
        int n;
        SW      = 1'b1;
        valE    = va;
        st_data = d;
        tick();
        SW = 1'b0;
        chk("st_err", {31'd0, addr_err}, {31'd0, exp_err});
        chk("st_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("st_lat", n, LAT + 1);
        $display("store addr=%h data=%h edges=%0d", va, d, n);
    endtask

    task automatic do_load(input logic [DW-1:0] va, input logic [3:0] tag,
                           input logic [DW-1:0] exp_data, input logic exp_err);
        int n;
        LW   = 1'b1;
        valE = va;
        dstE = tag;
        tick();
        LW = 1'b0;
        chk("ld_err", {31'd0, addr_err}, {31'd0, exp_err});
        chk("ld_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!LW_DONE && n < 20) begin
            tick();
            n++;
        end
        chk("ld_lat", n, LAT + 1);
        chk("ld_valM", valM, exp_data);
        chk("ld_dstM", {28'd0, dstM}, {28'd0, tag});
        chk("ld_busy_drop", {31'd0, busy}, 32'd0);
        tick();
        chk("ld_done_pulse", {31'd0, LW_DONE}, 32'd0);
        $display("load addr=%h tag=%0d data=%h edges=%0d", va, tag, valM, n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valM"}, valM, 32'd0);
        chk({tag, "_dstM"}, {28'd0, dstM}, 32'd0);
        chk({tag, "_done"}, {31'd0, LW_DONE}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, addr_err}, 32'd0);
    endtask

    initial begin
        int pulses;
        reset      = 1'b0;
        working    = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        pc_addr    = '0;
        LW         = 1'b0;
        SW         = 1'b0;
        valE       = '0;
        dstE       = '0;
        st_data    = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;

        // Host program load while idle.
        host_write(9'd0, 32'h1023_0005);
        host_write(9'd5, 32'h5555_5555);
        host_write(9'd7, 32'h7777_7777);
        host_write(9'd30, 32'h3030_3030);
        chk("instr_idle", instr, 32'd0);
        working = 1'b1;
        pc_addr = 9'd0;
        tick();
        chk("fetch0", instr, 32'h1023_0005);
        pc_addr = 9'd5;
        tick();
        chk("fetch5", instr, 32'h5555_5555);

        // Host write ignored while working.
        host_write(9'd5, 32'hFFFF_0000);
        tick();
        chk("fetch5_kept", instr, 32'h5555_5555);

        // Store then back-to-back load.
        do_store(32'd20, 32'hDEAD_BEEF, 1'b0);
        do_load(32'd20, 4'd3, 32'hDEAD_BEEF, 1'b0);

        // Illegal LW+SW.
        LW      = 1'b1;
        SW      = 1'b1;
        valE    = 32'd20;
        st_data = 32'h1234_5678;
        tick();
        LW = 1'b0;
        SW = 1'b0;
        chk("ill_err", {31'd0, addr_err}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("ill_err_pulse", {31'd0, addr_err}, 32'd0);
        $display("illegal LW+SW addr=%h", 32'd20);
        do_load(32'd20, 4'd4, 32'hDEAD_BEEF, 1'b0);

        // Out-of-range address wraps to word 5.
        do_load(32'h0000_0205, 4'd5, 32'h5555_5555, 1'b1);

        // Request while busy is dropped.
        LW   = 1'b1;
        valE = 32'd30;
        dstE = 4'd2;
        tick();
        LW      = 1'b0;
        SW      = 1'b1;
        valE    = 32'd7;
        st_data = 32'hAAAA_AAAA;
        tick();
        SW = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (LW_DONE) begin
                pulses++;
                chk("busy_ld_valM", valM, 32'h3030_3030);
            end
            tick();
        end
        chk("busy_pulses", pulses, 1);
        $display("load addr=%h with dropped store addr=%h pulses=%0d", 32'd30, 32'd7, pulses);
        do_load(32'd7, 4'd6, 32'h7777_7777, 1'b0);

        // Reset during WAIT of a store abandons it.
        SW      = 1'b1;
        valE    = 32'd30;
        st_data = 32'h0BAD_0BAD;
        tick();
        SW = 1'b0;
        chk("rst_wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("midrst");
        reset = 1'b1;
        tick();
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        $display("store addr=%h abandoned by reset", 32'd30);
        do_load(32'd30, 4'd1, 32'h3030_3030, 1'b0);

`ifdef LSU_STAT_EN
        reset = 1'b0;
        tick();
        chk("stat_rst_ld", {16'd0, ld_cnt}, 32'd0);
        chk("stat_rst_st", {16'd0, st_cnt}, 32'd0);
        reset = 1'b1;
        do_store(32'd40, 32'h0000_0040, 1'b0);
        do_store(32'd41, 32'h0000_0041, 1'b0);
        do_load(32'd40, 4'd7, 32'h0000_0040, 1'b0);
        do_load(32'd41, 4'd8, 32'h0000_0041, 1'b0);
        do_load(32'd0, 4'd9, 32'h1023_0005, 1'b0);
        chk("stat_ld", {16'd0, ld_cnt}, 32'd3);
        chk("stat_st", {16'd0, st_cnt}, 32'd2);
        reset = 1'b0;
        tick();
        chk("stat_clr_ld", {16'd0, ld_cnt}, 32'd0);
        chk("stat_clr_st", {16'd0, st_cnt}, 32'd0);
        reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
